// File: rtl/proc_trace_monitor.sv
// Run-control and trace unit for the 16-bit processor: captures retired PC/instruction
// pairs into a circular buffer, counts run cycles and halts the core on PC breakpoints.
module proc_trace_monitor #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 16,
  parameter int NUM_BP  = 2,
  parameter int CYC_W   = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   instr_valid,
  input  logic [PC_W-1:0]        pc,
  input  logic [INSTR_W-1:0]     instr,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  output logic                   halt_req,
  output logic                   running,
  output logic [CYC_W-1:0]       cycle_count,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [PC_W-1:0]        rd_pc,
  output logic [INSTR_W-1:0]     rd_instr,
  output logic [LVL_W-1:0]       level,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  state_t state, state_nxt;

  logic [PTR_W-1:0]         head, tail;
  logic [PC_W+INSTR_W-1:0]  mem [DEPTH];

  logic bp_match;
  logic arm_start;
  logic push;
  logic pop;
  logic hit;
  logic full;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    bp_match = 1'b0;
    for (int k = 0; k < NUM_BP; k++) begin
      if (bp_en[k] && (pc == bp_addr[k*PC_W +: PC_W])) bp_match = 1'b1;
    end
  end

  // arm is only honoured outside RUN; its clear takes priority over any push or pop.
  assign arm_start = arm && (state != S_RUN);
  assign push      = (state == S_RUN) && instr_valid;
  assign hit       = push && bp_match;
  assign full      = (level == LVL_W'(DEPTH));
  assign pop       = rd_valid && rd_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (arm) state_nxt = S_RUN;
      S_RUN:    if (hit) state_nxt = S_HALTED;
      S_HALTED: if (arm) state_nxt = S_RUN;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (arm_start) begin
      cycle_count <= '0;
    end else if ((state == S_RUN) && (cycle_count != '1)) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

  // Pop is never valid on an empty buffer, so a full push without a pop is the only overwrite.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (arm_start) begin
      head     <= '0;
      tail     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop || (push && full)) head <= head + 1'b1;
      if (push && !pop && full) overflow <= 1'b1;
      if (push && !pop && !full)    level <= level + 1'b1;
      else if (pop && !push)        level <= level - 1'b1;
    end
  end

  // NOTE: the trace storage has no reset; head/tail/level decide which entries are
  // meaningful, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= {pc, instr};
  end

  assign rd_valid = (level != '0);
  assign rd_pc    = mem[head][INSTR_W +: PC_W];
  assign rd_instr = mem[head][INSTR_W-1:0];
  assign halt_req = (state == S_HALTED);
  assign running  = (state == S_RUN);

endmodule
